// File: rtl/riscv_pkg.sv
// Shared register-file types for the writeback path.
package riscv_pkg;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] reg_idx;
    logic [XLEN-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the pending writeback entries for one lookup port.
module wb_fwd_match
  import riscv_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic [REG_IDX_W-1:0]       entry_reg  [DEPTH],
  input  logic [n-1:0]               entry_data [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [REG_IDX_W-1:0]       lookup_reg,
  output logic                       hit,
  output logic [n-1:0]               data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Walk oldest to youngest so the last valid match (the youngest) wins.
  always_comb begin
    hit  = 1'b0;
    data = {n{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (lookup_reg != ZERO_REG) &&
          (entry_reg[head + PW'(k)] == lookup_reg)) begin
        hit  = 1'b1;
        data = entry_data[head + PW'(k)];
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end
endmodule

// File: rtl/writeback_queue.sv
// Writeback FIFO in front of the register file write port, with read forwarding.
module writeback_queue
  import riscv_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [REG_IDX_W-1:0]       wb_reg,
  input  logic [n-1:0]               wb_data,
  input  logic                       drain_en,
  output logic                       write,
  output logic [REG_IDX_W-1:0]       write_reg,
  output logic [n-1:0]               write_data,
  input  logic [REG_IDX_W-1:0]       lookup_reg1,
  input  logic [REG_IDX_W-1:0]       lookup_reg2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [n-1:0]               fwd_data1,
  output logic [n-1:0]               fwd_data2,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_IDX_W-1:0] entry_reg_r  [DEPTH];
  logic [n-1:0]         entry_data_r [DEPTH];
  logic [PW-1:0]        head_r;
  logic [PW-1:0]        tail_r;
  logic [CW-1:0]        count_r;
  logic                 push_s;
  logic                 pop_s;

  // Writes to x0 complete the handshake but are dropped instead of stored.
  assign wb_ready = (count_r < CW'(DEPTH));
  assign push_s   = wb_valid && wb_ready && (wb_reg != ZERO_REG);
  assign pop_s    = write;
  assign count    = count_r;

  // Head entry drives the register file port whenever the queue is non-empty.
  always_comb begin
    if (count_r != {CW{1'b0}}) begin
      write      = drain_en;
      write_reg  = entry_reg_r[head_r];
      write_data = entry_data_r[head_r];
    end else begin
      write      = 1'b0;
      write_reg  = ZERO_REG;
      write_data = {n{1'b0}};
    end
  end

  // Entry storage; validity is tracked by head/count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      entry_reg_r[tail_r]  <= wb_reg;
      entry_data_r[tail_r] <= wb_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  wb_fwd_match #(.n(n), .DEPTH(DEPTH)) u_fwd1 (
    .entry_reg  (entry_reg_r),
    .entry_data (entry_data_r),
    .head       (head_r),
    .count      (count_r),
    .lookup_reg (lookup_reg1),
    .hit        (fwd_hit1),
    .data       (fwd_data1)
  );

  wb_fwd_match #(.n(n), .DEPTH(DEPTH)) u_fwd2 (
    .entry_reg  (entry_reg_r),
    .entry_data (entry_data_r),
    .head       (head_r),
    .count      (count_r),
    .lookup_reg (lookup_reg2),
    .hit        (fwd_hit2),
    .data       (fwd_data2)
  );
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench: queue-based reference model plus directed scenarios and random traffic.
module tb_writeback_queue;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_reg;
  logic [N-1:0]  wb_data;
  logic          drain_en;
  logic          write;
  logic [4:0]    write_reg;
  logic [N-1:0]  write_data;
  logic [4:0]    lookup_reg1;
  logic [4:0]    lookup_reg2;
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [N-1:0]  fwd_data1;
  logic [N-1:0]  fwd_data2;
  logic [2:0]    count;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] rf_model [32];
  logic [31:0] rf_dut   [32];
  logic [31:0] dut_commits[$];
  int          checks;
  int          errors;

  writeback_queue #(.n(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg(wb_reg), .wb_data(wb_data), .drain_en(drain_en),
    .write(write), .write_reg(write_reg), .write_data(write_data),
    .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_hit(input logic [4:0] r);
    for (int i = q.size() - 1; i >= 0; i--)
      if (r != 5'd0 && q[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_data(input logic [4:0] r);
    for (int i = q.size() - 1; i >= 0; i--)
      if (r != 5'd0 && q[i].r == r) return q[i].d;
    return 32'd0;
  endfunction

  // One clock: record DUT commit, advance the model with the current inputs, settle after the edge.
  task automatic tick();
    ent_t e;
    bit   room;
    @(negedge clk);
    if (write) begin
      rf_dut[write_reg] = write_data;
      dut_commits.push_back(write_data);
    end
    if (rst) begin
      q.delete();
    end else begin
      room = (q.size() < DEPTH);
      if (q.size() != 0 && drain_en) begin
        rf_model[q[0].r] = q[0].d;
        void'(q.pop_front());
      end
      if (wb_valid && room && wb_reg != 5'd0) begin
        e.r = wb_reg;
        e.d = wb_data;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    int ncommit;
    checks++;
    if (count !== 3'd0 || write !== 1'b0 || wb_ready !== 1'b1 || write_reg !== 5'd0 ||
        write_data !== 32'd0 || fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_initial got count=%0d write=%b ready=%b wreg=%0d wdata=%h hit=%b",
               count, write, wb_ready, write_reg, write_data, fwd_hit1);
    end
    drain_en    = 1'b0;
    lookup_reg1 = 5'd2;
    push(5'd1, 32'h1111_0001);
    push(5'd2, 32'h1111_0002);
    push(5'd3, 32'h1111_0003);
    ncommit = dut_commits.size();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || write !== 1'b0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got count=%0d write=%b ready=%b exp 0 0 1", count, write, wb_ready);
    end
    checks++;
    if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_fwd got hit=%b data=%h exp 0 0", fwd_hit1, fwd_data1);
    end
    drain_en = 1'b1;
    #1;
    checks++;
    if (write !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_commit got write=%b exp 0", write);
    end
    tick();
    checks++;
    if (dut_commits.size() != ncommit) begin
      errors++;
      $display("FAIL reset_discard got commits=%0d exp %0d", dut_commits.size(), ncommit);
    end
  endtask

  task automatic test_single();
    drain_en = 1'b1;
    push(5'd5, 32'hDEAD_BEEF);
    checks++;
    if (write !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_commit got write=%b reg=%0d data=%h exp 1 5 deadbeef",
               write, write_reg, write_data);
    end
    tick();
    checks++;
    if (count !== 3'd0 || rf_dut[5] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_rf got count=%0d x5=%h exp 0 deadbeef", count, rf_dut[5]);
    end
  endtask

  task automatic test_fill();
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h11 * i);
    checks++;
    if (count !== 3'd4 || wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got count=%0d ready=%b exp 4 0", count, wb_ready);
    end
    push(5'd9, 32'h99);
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL fill_reject got count=%0d exp 4", count);
    end
    drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if (write !== 1'b1 || write_reg !== 5'(i) || write_data !== 32'h11 * i) begin
        errors++;
        $display("FAIL fill_drain_%0d got write=%b reg=%0d data=%h exp 1 %0d %h",
                 i, write, write_reg, write_data, i, 32'h11 * i);
      end
      tick();
      if (i == 1) begin
        checks++;
        if (wb_ready !== 1'b1) begin
          errors++;
          $display("FAIL fill_ready got %b exp 1", wb_ready);
        end
      end
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL fill_empty got count=%0d exp 0", count);
    end
  endtask

  task automatic test_forward();
    drain_en = 1'b0;
    push(5'd7, 32'hA);
    push(5'd3, 32'hB);
    push(5'd7, 32'hC);
    lookup_reg1 = 5'd7;
    lookup_reg2 = 5'd3;
    #1;
    checks++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hC || fwd_hit2 !== 1'b1 || fwd_data2 !== 32'hB) begin
      errors++;
      $display("FAIL fwd_youngest got hit1=%b d1=%h hit2=%b d2=%h exp 1 c 1 b",
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    end
    drain_en = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (rf_dut[7] !== 32'hC || fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin
      errors++;
      $display("FAIL fwd_drained got x7=%h hit1=%b hit2=%b exp c 0 0", rf_dut[7], fwd_hit1, fwd_hit2);
    end
  endtask

  task automatic test_zero_reg();
    drain_en    = 1'b1;
    wb_valid    = 1'b1;
    wb_reg      = 5'd0;
    wb_data     = 32'hFFFF;
    lookup_reg1 = 5'd0;
    #1;
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready got %b exp 1", wb_ready);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || write !== 1'b0 || fwd_hit1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_dropped got count=%0d write=%b hit=%b exp 0 0 0", count, write, fwd_hit1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    int start;
    drain_en = 1'b1;
    start = dut_commits.size();
    for (int i = 0; i <= 3 * DEPTH; i++) begin
      wb_valid = 1'b1;
      wb_reg   = 5'((i % 31) + 1);
      wb_data  = 32'h100 + i;
      exp_q.push_back(32'h100 + i);
      tick();
      checks++;
      if (count !== 3'd1) begin
        errors++;
        $display("FAIL b2b_count_%0d got %0d exp 1", i, count);
      end
    end
    wb_valid = 1'b0;
    tick();
    checks++;
    if (dut_commits.size() - start != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_len got %0d exp %0d", dut_commits.size() - start, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (dut_commits[start + k] !== exp_q[k]) begin
          errors++;
          $display("FAIL b2b_order_%0d got %h exp %h", k, dut_commits[start + k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_wd;
    logic [4:0]  exp_wr;
    for (int c = 0; c < 400; c++) begin
      wb_valid    = ($urandom_range(0, 3) != 0);
      wb_reg      = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      drain_en    = ($urandom_range(0, 2) != 0);
      lookup_reg1 = 5'($urandom_range(0, 7));
      lookup_reg2 = 5'($urandom_range(0, 7));
      #1;
      exp_wr = (q.size() != 0) ? q[0].r : 5'd0;
      exp_wd = (q.size() != 0) ? q[0].d : 32'd0;
      checks++;
      if (count !== 3'(q.size()) || wb_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_occ_%0d got count=%0d ready=%b exp %0d", c, count, wb_ready, q.size());
      end
      checks++;
      if (write !== (q.size() != 0 && drain_en) || write_reg !== exp_wr || write_data !== exp_wd) begin
        errors++;
        $display("FAIL rnd_commit_%0d got w=%b r=%0d d=%h exp r=%0d d=%h",
                 c, write, write_reg, write_data, exp_wr, exp_wd);
      end
      checks++;
      if (fwd_hit1 !== m_hit(lookup_reg1) || fwd_data1 !== m_data(lookup_reg1) ||
          fwd_hit2 !== m_hit(lookup_reg2) || fwd_data2 !== m_data(lookup_reg2)) begin
        errors++;
        $display("FAIL rnd_fwd_%0d got %b/%h %b/%h exp %b/%h %b/%h", c,
                 fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
                 m_hit(lookup_reg1), m_data(lookup_reg1), m_hit(lookup_reg2), m_data(lookup_reg2));
      end
      tick();
    end
    wb_valid = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i <= DEPTH; i++) tick();
    checks++;
    for (int r = 0; r < 32; r++) begin
      if (rf_dut[r] !== rf_model[r]) begin
        errors++;
        $display("FAIL rnd_rf x%0d got %h exp %h", r, rf_dut[r], rf_model[r]);
        break;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int r = 0; r < 32; r++) begin
      rf_model[r] = 32'd0;
      rf_dut[r]   = 32'd0;
    end
    rst = 1'b1;
    wb_valid = 1'b0;
    wb_reg = 5'd0;
    wb_data = 32'd0;
    drain_en = 1'b0;
    lookup_reg1 = 5'd0;
    lookup_reg2 = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_zero_reg();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-side initiator for the N-bit register file. Buffers writeback requests (register index, data) from the execute/memory stages in a small FIFO.
- Drains at most one entry per cycle into the register file's single write port.
- Provides read-forwarding so decode sees the newest pending value of any register not yet committed.
- Sits between the writeback stage and the register file's write, write_reg and write_data ports.

Parameters:
- n, 32, data width; must match the register file width.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- wb_valid  input  1  writeback request present
- wb_ready  output  1  queue can accept a request this cycle
- wb_reg  input  5  destination register index
- wb_data  input  n  destination data
- drain_en  input  1  permits draining this cycle; 0 pauses commits
- write  output  1  register file write enable
- write_reg  output  5  register file write index
- write_data  output  n  register file write data
- lookup_reg1  input  5  forwarding query 1
- lookup_reg2  input  5  forwarding query 2
- fwd_hit1  output  1  pending entry exists for lookup_reg1
- fwd_hit2  output  1  pending entry exists for lookup_reg2
- fwd_data1  output  n  youngest pending data for lookup_reg1
- fwd_data2  output  n  youngest pending data for lookup_reg2
- count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- **Reset** (rst=1 at clk edge): head, tail and count cleared; all entries invalid. Outputs after reset: write=0, write_reg=0, write_data=0, wb_ready=1, fwd_hit*=0, fwd_data*=0, count=0. A reset mid-operation discards all pending entries without committing them.
- **Enqueue:** a push occurs when wb_valid && wb_ready at the clk edge. Requests with wb_reg=0 are accepted (handshake completes) but not stored; count is unchanged.
- **Ready:** wb_ready = (count < DEPTH). It does not depend on a same-cycle pop, so there is no combinational path from drain_en to wb_ready.
- **Commit (combinational from the head entry):** write = (count != 0) && drain_en. write_reg and write_data equal the head entry when count != 0, and 0 otherwise.
- **Pop:** when write=1, the head pops at the same clk edge at which the register file captures the data.
- **Latency:** a push into an empty queue appears on write/write_reg/write_data in the next cycle. Throughput is 1 entry per cycle.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
  - When full: no push is possible, since wb_ready=0. The pop still occurs.
  - When count=1: the new entry becomes the head next cycle.
- **Pointer wrap:** head and tail wrap modulo DEPTH. count distinguishes full from empty.
- **Ordering:** strict FIFO. Multiple pending writes to the same register commit in order, so the register file ends with the youngest value.
- **Forwarding** (fully combinational, per query): scans valid entries from tail-1 back to head and returns the youngest match.
  - The head entry being committed this cycle is still visible to queries.
  - The request being pushed this cycle is not visible until the next cycle.
  - lookup_reg=0 never hits.
  - On a miss, fwd_data = 0.
- **Widths:** count saturates at DEPTH by construction. The pointers are $clog2(DEPTH) bits wide.

Decomposition:
- **Shared package** (riscv_pkg):
  - REG_IDX_W = 5
  - ZERO_REG = 5'd0
  - wb_entry_t struct: reg_idx, data
- **Sub-module:** wb_fwd_match, combinational youngest-match search over the entry array. It is instantiated twice, once per lookup port.
- **Top level:** owns the FIFO storage, pointers and count.

Test Plan:
1. Reset then idle, with rst=1 for 2 cycles mid-traffic → after release: count=0, write=0, wb_ready=1. No commit of the entries discarded by reset.
2. Single push of reg 5 / 0xDEADBEEF into an empty queue with drain_en=1 → next cycle: write=1, write_reg=5, write_data=0xDEADBEEF. Following cycle: count=0; a register file read of x5 returns 0xDEADBEEF.
3. drain_en=0, push regs 1..4 (data 0x11..0x44) → count=4, wb_ready=0, and a 5th push is not accepted. Raise drain_en → commits 1,2,3,4 in 4 consecutive cycles; wb_ready returns to 1 one cycle after the first pop.
4. drain_en=0, push (7, 0xA), (3, 0xB), (7, 0xC); lookup_reg1=7, lookup_reg2=3 → fwd_hit1=1 with fwd_data1=0xC; fwd_hit2=1 with fwd_data2=0xB. After full drain, register x7=0xC and both hits=0.
5. Push (0, 0xFFFF) → wb_ready handshake completes, count stays 0, and write never asserts. lookup_reg1=0 → fwd_hit1=0.
6. Continuous push/pop for 3×DEPTH cycles with incrementing data → pointers wrap, count stays at 1, and committed data follows exact push order with no loss or duplication.
